time_counter: RTL

24-hour BCD time-of-day counter for the digital clock. It consumes the one-cycle-per-second tick from the clock divider and advances seconds, minutes and hours. It provides a set mode in which the user adjusts minutes and hours with pre-debounced key pulses, and it drives the display decoder and chime logic with registered BCD digits and rollover pulses.

---
 rtl/time_counter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/time_counter.sv
// time_counter: 24-hour BCD time-of-day counter.
//
// Advances seconds, minutes and hours on each one-second tick in run mode. In set
// mode the seconds are held at 00 and minutes and hours step on key pulses without
// carrying into each other. All outputs are registered.
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset (highest priority)
//   tick        one-cycle pulse per second from the divider
//   set_en      level, 1 = set mode, 0 = run mode
//   inc_min     one-cycle key pulse, steps minutes in set mode
//   inc_hour    one-cycle key pulse, steps hours in set mode
//   sec_bcd     seconds, BCD {tens, ones}, 00..59
//   min_bcd     minutes, BCD, 00..59
//   hour_bcd    hours, BCD, 00..23
//   min_carry   pulse when seconds wrap 59 -> 00 in run mode
//   hour_chime  pulse when minutes wrap 59 -> 00 in run mode
//   day_wrap    pulse on 23:59:59 -> 00:00:00
module time_counter #(
    parameter logic [7:0] RESET_HOUR = 8'h00,
    parameter logic [7:0] RESET_MIN  = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       set_en,
    input  logic       inc_min,
    input  logic       inc_hour,
    output logic [7:0] sec_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] hour_bcd,
    output logic       min_carry,
    output logic       hour_chime,
    output logic       day_wrap
);

    logic [7:0] sec_q, sec_d;
    logic [7:0] min_q, min_d;
    logic [7:0] hour_q, hour_d;
    logic       min_carry_q, min_carry_d;
    logic       hour_chime_q, hour_chime_d;
    logic       day_wrap_q, day_wrap_d;

    // BCD increment modulo 60; 59 wraps to 00.
    function automatic logic [7:0] inc_mod60(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) begin
            if (v[7:4] == 4'd5) begin
                r = 8'h00;
            end else begin
                r = {v[7:4] + 4'd1, 4'd0};
            end
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    // BCD increment modulo 24; 23 wraps to 00, 09 -> 10 and 19 -> 20.
    function automatic logic [7:0] inc_mod24(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h23) begin
            r = 8'h00;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    logic sec_wrap, min_wrap;

    assign sec_wrap = (sec_q == 8'h59);
    assign min_wrap = sec_wrap && (min_q == 8'h59);

    always_comb begin
        sec_d        = sec_q;
        min_d        = min_q;
        hour_d       = hour_q;
        min_carry_d  = 1'b0;
        hour_chime_d = 1'b0;
        day_wrap_d   = 1'b0;

        if (set_en) begin
            // Set mode: seconds pinned to 00, ticks dropped, no cross-digit carry.
            sec_d = 8'h00;
            if (inc_min) begin
                min_d = inc_mod60(min_q);
            end
            if (inc_hour) begin
                hour_d = inc_mod24(hour_q);
            end
        end else if (tick) begin
            sec_d       = inc_mod60(sec_q);
            min_carry_d = sec_wrap;
            if (sec_wrap) begin
                min_d = inc_mod60(min_q);
            end
            hour_chime_d = min_wrap;
            if (min_wrap) begin
                hour_d     = inc_mod24(hour_q);
                day_wrap_d = (hour_q == 8'h23);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sec_q        <= 8'h00;
            min_q        <= RESET_MIN;
            hour_q       <= RESET_HOUR;
            min_carry_q  <= 1'b0;
            hour_chime_q <= 1'b0;
            day_wrap_q   <= 1'b0;
        end else begin
            sec_q        <= sec_d;
            min_q        <= min_d;
            hour_q       <= hour_d;
            min_carry_q  <= min_carry_d;
            hour_chime_q <= hour_chime_d;
            day_wrap_q   <= day_wrap_d;
        end
    end

    assign sec_bcd    = sec_q;
    assign min_bcd    = min_q;
    assign hour_bcd   = hour_q;
    assign min_carry  = min_carry_q;
    assign hour_chime = hour_chime_q;
    assign day_wrap   = day_wrap_q;

endmodule
